// File: rtl/sw_pkg.sv
// Shared widths, input-FSM state type and word-type decoders for the switcher core.
package sw_pkg;
  localparam int SW_DATA_WIDTH    = 65;
  localparam int SW_TOTAL_INPUTS  = 2;
  localparam int SW_TOTAL_OUTPUTS = 2;
  localparam int SW_DEST_LSB      = 0;
  localparam int SW_DEST_W        = 4;

  typedef enum logic [1:0] {IDLE, REQ, STREAM, DROP} in_state_e;

  // tag = {meta, header-flag}, the two MSBs of a word
  function automatic logic is_header(input logic [1:0] tag);
    return tag == 2'b11;
  endfunction

  function automatic logic is_footer(input logic [1:0] tag);
    return tag == 2'b10;
  endfunction
endpackage

// File: rtl/sw_switcher_core_if.sv
// Bundle of input-buffer read ports and output-buffer write ports; master = switcher core.
interface sw_switcher_core_if import sw_pkg::*; #(
  parameter int DATA_WIDTH    = SW_DATA_WIDTH,
  parameter int TOTAL_INPUTS  = SW_TOTAL_INPUTS,
  parameter int TOTAL_OUTPUTS = SW_TOTAL_OUTPUTS
) ();
  logic [TOTAL_INPUTS-1:0][DATA_WIDTH-1:0]  in_data;
  logic [TOTAL_INPUTS-1:0]                  in_empty;
  logic [TOTAL_INPUTS-1:0]                  in_ren;
  logic [TOTAL_INPUTS-1:0]                  route_err;
  logic [TOTAL_OUTPUTS-1:0][DATA_WIDTH-1:0] out_data;
  logic [TOTAL_OUTPUTS-1:0]                 out_wen;
  logic [TOTAL_OUTPUTS-1:0]                 out_almost_full;

  modport master (
    input  in_data, in_empty, out_almost_full,
    output in_ren, out_data, out_wen, route_err
  );

  modport slave (
    output in_data, in_empty, out_almost_full,
    input  in_ren, out_data, out_wen, route_err
  );
endinterface

// File: rtl/sw_rr_arbiter.sv
// Round-robin arbiter for one output: grant is combinational while unlocked, then held
// (registered owner) until release_i marks the owner's footer pop.
module sw_rr_arbiter import sw_pkg::*; #(
  parameter int N = SW_TOTAL_INPUTS
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [N-1:0] req_i,
  input  logic         release_i,
  output logic [N-1:0] gnt_o
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  owner_q, pick;
  logic          locked_q, found;
  logic [PW-1:0] ptr_q, ptr_d;

  // ptr_q is the highest-priority requester; it moves just past each winner
  always_comb begin
    pick  = '0;
    found = 1'b0;
    ptr_d = ptr_q;
    for (int k = 0; k < N; k++) begin
      if (!found && req_i[(int'(ptr_q) + k) % N]) begin
        found = 1'b1;
        pick[(int'(ptr_q) + k) % N] = 1'b1;
        ptr_d = PW'((int'(ptr_q) + k + 1) % N);
      end
    end
  end

  assign gnt_o = locked_q ? owner_q : pick;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      owner_q  <= '0;
      locked_q <= 1'b0;
      ptr_q    <= '0;
    end else if (locked_q) begin
      if (release_i) locked_q <= 1'b0;
    end else if (found) begin
      owner_q  <= pick;
      locked_q <= 1'b1;
      ptr_q    <= ptr_d;
    end
  end
endmodule

// File: rtl/sw_switcher_core.sv
// Event-level crossbar: routes whole header..footer events from FWFT input buffers to the
// output buffer named by the header dest. SW_EVENT_COUNTERS_EN adds evt_count/drop_count.
module sw_switcher_core import sw_pkg::*; #(
  parameter int DATA_WIDTH    = SW_DATA_WIDTH,
  parameter int TOTAL_INPUTS  = SW_TOTAL_INPUTS,
  parameter int TOTAL_OUTPUTS = SW_TOTAL_OUTPUTS,
  parameter int DEST_LSB      = SW_DEST_LSB,
  parameter int DEST_W        = SW_DEST_W
) (
  input  logic clock,
  input  logic reset_n,
  sw_switcher_core_if.master sw
`ifdef SW_EVENT_COUNTERS_EN
  ,
  output logic [TOTAL_OUTPUTS-1:0][31:0] evt_count,
  output logic [TOTAL_INPUTS-1:0][15:0]  drop_count
`endif
);
  localparam int TI = TOTAL_INPUTS;
  localparam int TO = TOTAL_OUTPUTS;
  localparam int DW = DATA_WIDTH;

  in_state_e                 state_q [TI];
  logic [TI-1:0][DEST_W-1:0] dest_q, head_dest;
  logic                      active_q;
  logic [TI-1:0]             avail, hdr, ftr, dest_ok, blk, granted, pop, fwd, drop_start;
  logic [TI-1:0]             route_err_q;
  logic [TO-1:0][TI-1:0]     req, gnt;
  logic [TO-1:0]             rel, out_wen_q, out_wen_d;
  logic [TO-1:0][DW-1:0]     out_data_q, out_data_d;

  always_comb begin
    for (int i = 0; i < TI; i++) begin
      head_dest[i]  = sw.in_data[i][DEST_LSB +: DEST_W];
      avail[i]      = active_q && !sw.in_empty[i];
      hdr[i]        = is_header(sw.in_data[i][DW-1 -: 2]);
      ftr[i]        = is_footer(sw.in_data[i][DW-1 -: 2]);
      dest_ok[i]    = int'(head_dest[i]) < TO;
      drop_start[i] = (state_q[i] == IDLE) && avail[i] && hdr[i] && !dest_ok[i];
      blk[i]        = 1'b0;
      for (int o = 0; o < TO; o++)
        if (dest_q[i] == DEST_W'(o)) blk[i] = sw.out_almost_full[o];
      case (state_q[i])
        IDLE:    pop[i] = avail[i] && !hdr[i];
        STREAM:  pop[i] = avail[i] && !blk[i];
        DROP:    pop[i] = avail[i];
        default: pop[i] = 1'b0;
      endcase
      fwd[i] = (state_q[i] == STREAM) && pop[i];
    end
  end

  always_comb begin
    req = '0;
    for (int o = 0; o < TO; o++)
      for (int i = 0; i < TI; i++)
        req[o][i] = (state_q[i] == REQ) && (dest_q[i] == DEST_W'(o));
  end

  always_comb begin
    granted = '0;
    for (int i = 0; i < TI; i++)
      for (int o = 0; o < TO; o++)
        if (dest_q[i] == DEST_W'(o)) granted[i] = gnt[o][i];
  end

  // Only the locked owner can be streaming into an output, so this OR-mux never collides
  always_comb begin
    rel        = '0;
    out_wen_d  = '0;
    out_data_d = out_data_q;
    for (int o = 0; o < TO; o++)
      for (int i = 0; i < TI; i++)
        if (fwd[i] && dest_q[i] == DEST_W'(o)) begin
          out_wen_d[o]  = 1'b1;
          out_data_d[o] = sw.in_data[i];
          rel[o]        = ftr[i];
        end
  end

  for (genvar o = 0; o < TO; o++) begin : g_arb
    sw_rr_arbiter #(.N(TI)) u_arb (
      .clock     (clock),
      .reset_n   (reset_n),
      .req_i     (req[o]),
      .release_i (rel[o]),
      .gnt_o     (gnt[o])
    );
  end

  // active_q keeps in_ren low while reset is asserted and for the first cycle after release
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active_q    <= 1'b0;
      route_err_q <= '0;
      out_wen_q   <= '0;
      out_data_q  <= '0;
      dest_q      <= '0;
      for (int i = 0; i < TI; i++) state_q[i] <= IDLE;
    end else begin
      active_q    <= 1'b1;
      route_err_q <= drop_start;
      out_wen_q   <= out_wen_d;
      out_data_q  <= out_data_d;
      for (int i = 0; i < TI; i++) begin
        case (state_q[i])
          IDLE: if (avail[i] && hdr[i]) begin
            dest_q[i]  <= head_dest[i];
            state_q[i] <= dest_ok[i] ? REQ : DROP;
          end
          REQ:     if (granted[i]) state_q[i] <= STREAM;
          STREAM:  if (fwd[i] && ftr[i]) state_q[i] <= IDLE;
          DROP:    if (pop[i] && ftr[i]) state_q[i] <= IDLE;
          default: state_q[i] <= IDLE;
        endcase
      end
    end
  end

  assign sw.in_ren    = pop;
  assign sw.out_wen   = out_wen_q;
  assign sw.out_data  = out_data_q;
  assign sw.route_err = route_err_q;

`ifdef SW_EVENT_COUNTERS_EN
  logic [TO-1:0][31:0] evt_q;
  logic [TI-1:0][15:0] drop_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      evt_q  <= '0;
      drop_q <= '0;
    end else begin
      for (int o = 0; o < TO; o++)
        if (out_wen_q[o] && is_footer(out_data_q[o][DW-1 -: 2])) evt_q[o] <= evt_q[o] + 32'd1;
      for (int i = 0; i < TI; i++)
        if (drop_start[i] && drop_q[i] != 16'hFFFF) drop_q[i] <= drop_q[i] + 16'd1;
    end
  end

  assign evt_count  = evt_q;
  assign drop_count = drop_q;
`endif
endmodule
